// File: rtl/awgn_pkg.sv
// Shared types and widths for the AWGN burst sequencer.
package awgn_pkg;
    localparam int SEED_W   = 192;
    localparam int SAMPLE_W = 16;
    localparam int OVF_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        WARMUP,
        RUN,
        DRAIN
    } state_t;
endpackage

// File: rtl/awgn_sample_fifo.sv
// First-word fall-through sample-pair buffer; head is visible the cycle after its push.
module awgn_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot, so a full buffer still accepts
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/awgn_burst_ctrl.sv
// Seeds, warms up and bursts the free-running AWGN datapath into a valid/ready stream.
//   state  | meaning
//   IDLE   | generator held in reset, waiting for start
//   SEED   | seeds stable on seed_bus, gen_rst held for SEED_CYCLES
//   WARMUP | generator running, samples discarded for WARMUP_CYCLES
//   RUN    | one pair per cycle pushed (or dropped when full)
//   DRAIN  | generator stopped, waiting for FIFO to empty
module awgn_burst_ctrl
    import awgn_pkg::*;
#(
    parameter int SEED_CYCLES   = 2,
    parameter int WARMUP_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_W         = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [CNT_W-1:0]           burst_len,
    input  logic [SEED_W-1:0]          seed_in,
    output logic [SEED_W-1:0]          seed_bus,
    output logic                       gen_rst,
    input  logic signed [SAMPLE_W-1:0] awgn_in1,
    input  logic signed [SAMPLE_W-1:0] awgn_in2,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [2*SAMPLE_W-1:0]      m_data,
    output logic                       busy,
    output logic                       done,
    output logic [OVF_W-1:0]           overflow_cnt
);
    state_t             state, state_nxt;
    logic [CNT_W-1:0]   tmr, tmr_nxt;
    logic [CNT_W-1:0]   gen_cnt, gen_cnt_nxt;
    logic [CNT_W-1:0]   burst_len_q;
    logic [SEED_W-1:0]  seed_q;
    logic [OVF_W-1:0]   ovf_q;
    logic               start_ok;
    logic               push;
    logic               pop;
    logic               drop;
    logic               flush;
    logic               full;
    logic               empty;

    assign start_ok     = (state == IDLE) && start && !abort;
    assign flush        = start_ok || abort;
    assign pop          = !empty && m_ready;
    assign drop         = push && full && !pop;
    assign busy         = (state != IDLE);
    assign m_valid      = !empty;
    assign seed_bus     = seed_q;
    assign overflow_cnt = ovf_q;

    always_comb begin
        state_nxt   = state;
        tmr_nxt     = tmr;
        gen_cnt_nxt = gen_cnt;
        gen_rst     = 1'b1;
        push        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt   = SEED;
                    tmr_nxt     = CNT_W'(SEED_CYCLES - 1);
                    gen_cnt_nxt = '0;
                end
            end
            SEED: begin
                if (tmr == '0) begin
                    if (WARMUP_CYCLES == 0) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = WARMUP;
                        tmr_nxt   = CNT_W'(WARMUP_CYCLES - 1);
                    end
                end else begin
                    tmr_nxt = tmr - CNT_W'(1);
                end
            end
            WARMUP: begin
                gen_rst = 1'b0;
                if (tmr == '0) state_nxt = RUN;
                else           tmr_nxt   = tmr - CNT_W'(1);
            end
            RUN: begin
                gen_rst     = 1'b0;
                push        = 1'b1;
                gen_cnt_nxt = gen_cnt + CNT_W'(1);
                // zero length means continuous; only abort leaves RUN then
                if ((burst_len_q != '0) && (gen_cnt_nxt == burst_len_q)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (empty) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
            push      = 1'b0;
            done      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            tmr         <= '0;
            gen_cnt     <= '0;
            burst_len_q <= '0;
            seed_q      <= '0;
            ovf_q       <= '0;
        end else begin
            state   <= state_nxt;
            tmr     <= tmr_nxt;
            gen_cnt <= gen_cnt_nxt;
            if (start_ok) begin
                burst_len_q <= burst_len;
                seed_q      <= seed_in;
                ovf_q       <= '0;
            end else if (drop && (ovf_q != '1)) begin
                ovf_q <= ovf_q + OVF_W'(1);
            end
        end
    end

    awgn_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*SAMPLE_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data ({awgn_in2, awgn_in1}),
        .rd_data (m_data),
        .full    (full),
        .empty   (empty)
    );
endmodule

// File: tb/tb_awgn_burst_ctrl.sv
// Directed bench for awgn_burst_ctrl with a counting generator model driven by gen_rst.
module tb_awgn_burst_ctrl;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         m_ready = 1'b0;
    logic [15:0]  burst_len = '0;
    logic [191:0] seed_in = '0;
    logic [191:0] seed_bus;
    logic         gen_rst;
    logic [15:0]  awgn_in1;
    logic [15:0]  awgn_in2;
    logic         m_valid;
    logic [31:0]  m_data;
    logic         busy;
    logic         done;
    logic [7:0]   overflow_cnt;
    logic [15:0]  gen_idx;

    int total = 0;
    int passed = 0;
    int t, pops, dones, first_valid, done_t;

    localparam logic [191:0] SEED_A = {32'h6666_0006, 32'h5555_0005, 32'h4444_0004,
                                       32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    localparam logic [191:0] SEED_B = {32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hCAFE_BABE,
                                       32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F};
    localparam logic [191:0] SEED_C = {32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_FFFF,
                                       32'hFFFF_0000, 32'h1357_9BDF, 32'h2468_ACE0};

    awgn_burst_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .burst_len    (burst_len),
        .seed_in      (seed_in),
        .seed_bus     (seed_bus),
        .gen_rst      (gen_rst),
        .awgn_in1     (awgn_in1),
        .awgn_in2     (awgn_in2),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .busy         (busy),
        .done         (done),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    // generator model: sample index restarts while held in reset
    always @(posedge clk) begin
        if (gen_rst) gen_idx <= '0;
        else         gen_idx <= gen_idx + 16'd1;
    end
    assign awgn_in1 = 16'h1000 + gen_idx;
    assign awgn_in2 = 16'hC000 - gen_idx;

    function automatic logic [31:0] exp_pair(input int i);
        logic [15:0] s;
        s = 16'(i);
        return {16'hC000 - s, 16'h1000 + s};
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // observe what the coming edge will see, then advance one cycle
    task automatic tick();
        if (m_valid && m_ready) begin
            chk("pop_data", 192'(m_data), 192'(exp_pair(4 + pops)));
            pops++;
        end
        if (m_valid && first_valid < 0) first_valid = t;
        if (done) begin
            dones++;
            done_t = t;
        end
        @(negedge clk);
        t++;
    endtask

    task automatic launch(input logic [15:0] len, input logic [191:0] seed);
        t = 0; pops = 0; dones = 0; first_valid = -1; done_t = -1;
        burst_len = len;
        seed_in   = seed;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_gen_rst", 192'(gen_rst), 192'(1));
        chk("rst_busy", 192'(busy), 192'(0));
        chk("rst_m_valid", 192'(m_valid), 192'(0));
        chk("rst_m_data", 192'(m_data), 192'(0));
        chk("rst_seed_bus", seed_bus, 192'(0));
        chk("rst_overflow", 192'(overflow_cnt), 192'(0));
        reset = 1'b1;

        repeat (20) @(negedge clk);
        chk("idle_gen_rst", 192'(gen_rst), 192'(1));
        chk("idle_busy", 192'(busy), 192'(0));
        chk("idle_m_valid", 192'(m_valid), 192'(0));
        chk("idle_overflow", 192'(overflow_cnt), 192'(0));

        seed_in = SEED_A; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 192'(busy), 192'(0));
        chk("start_abort_seed", seed_bus, 192'(0));

        // burst of 10 with consumer always ready
        m_ready = 1'b1;
        launch(16'd10, SEED_A);
        chk("b10_seed_latch", seed_bus, SEED_A);
        chk("b10_gen_rst_t1", 192'(gen_rst), 192'(1));
        tick();
        chk("b10_gen_rst_t2", 192'(gen_rst), 192'(1));
        tick();
        chk("b10_gen_rst_t3", 192'(gen_rst), 192'(0));
        chk("b10_busy", 192'(busy), 192'(1));
        while (t < 25) tick();
        chk("b10_first_valid", 192'(first_valid), 192'(8));
        chk("b10_pops", 192'(pops), 192'(10));
        chk("b10_dones", 192'(dones), 192'(1));
        chk("b10_done_t", 192'(done_t), 192'(18));
        chk("b10_overflow", 192'(overflow_cnt), 192'(0));
        chk("b10_busy_end", 192'(busy), 192'(0));

        // burst of 20 with consumer stalled through RUN
        m_ready = 1'b0;
        launch(16'd20, SEED_B);
        while (t < 27) tick();
        chk("b20_overflow_run", 192'(overflow_cnt), 192'(16));
        chk("b20_m_valid", 192'(m_valid), 192'(1));
        m_ready = 1'b1;
        while (t < 35) tick();
        chk("b20_pops", 192'(pops), 192'(4));
        chk("b20_dones", 192'(dones), 192'(1));
        chk("b20_done_t", 192'(done_t), 192'(31));
        chk("b20_overflow_end", 192'(overflow_cnt), 192'(16));

        // fill the FIFO, then push and pop every cycle while full
        m_ready = 1'b0;
        launch(16'd30, SEED_A);
        chk("b30_overflow_clr", 192'(overflow_cnt), 192'(0));
        while (t < 11) tick();
        chk("b30_full_valid", 192'(m_valid), 192'(1));
        m_ready = 1'b1;
        while (t < 45) tick();
        chk("b30_pops", 192'(pops), 192'(30));
        chk("b30_overflow", 192'(overflow_cnt), 192'(0));
        chk("b30_dones", 192'(dones), 192'(1));
        chk("b30_done_t", 192'(done_t), 192'(41));

        // continuous mode ended by abort
        m_ready = 1'b1;
        launch(16'd0, SEED_B);
        while (t < 57) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("cont_abort_busy", 192'(busy), 192'(0));
        chk("cont_abort_valid", 192'(m_valid), 192'(0));
        chk("cont_abort_gen_rst", 192'(gen_rst), 192'(1));
        chk("cont_pops", 192'(pops), 192'(50));
        repeat (5) tick();
        chk("cont_no_done", 192'(dones), 192'(0));

        // restart with new seeds; a start while busy must be ignored
        launch(16'd6, SEED_C);
        chk("b6_seed_new", seed_bus, SEED_C);
        while (t < 4) tick();
        start = 1'b1; burst_len = 16'd2; seed_in = SEED_A;
        tick();
        start = 1'b0;
        chk("b6_seed_kept", seed_bus, SEED_C);
        while (t < 20) tick();
        chk("b6_pops", 192'(pops), 192'(6));
        chk("b6_dones", 192'(dones), 192'(1));
        chk("b6_done_t", 192'(done_t), 192'(14));

        // asynchronous reset with three entries buffered
        m_ready = 1'b0;
        launch(16'd0, SEED_A);
        while (t < 10) tick();
        chk("mid_m_valid", 192'(m_valid), 192'(1));
        chk("mid_m_data", 192'(m_data), 192'(exp_pair(4)));
        reset = 1'b0;
        #1;
        chk("mid_rst_gen_rst", 192'(gen_rst), 192'(1));
        chk("mid_rst_busy", 192'(busy), 192'(0));
        chk("mid_rst_m_valid", 192'(m_valid), 192'(0));
        chk("mid_rst_m_data", 192'(m_data), 192'(0));
        chk("mid_rst_seed", seed_bus, 192'(0));
        chk("mid_rst_done", 192'(done), 192'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 192'(busy), 192'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/awgn_burst_ctrl.md
Name: awgn_burst_ctrl

Overview:
Sequencer for the dual-Tausworthe/Box-Muller AWGN datapath. It latches a 192-bit seed set and holds the generator in reset while the seeds load. It then discards warm-up samples while the log/sqrt/sincos pipeline fills, and streams a programmed burst of sample pairs to a downstream consumer over valid/ready. The datapath is free-running and cannot stall, so the block buffers samples in a small FIFO and counts any it must drop.

Parameters:
SEED_CYCLES, 2, cycles gen_rst is held high with seeds stable (min 1)
WARMUP_CYCLES, 4, datapath samples discarded after gen_rst release (min 0)
FIFO_DEPTH, 4, sample-pair buffer entries (power of 2, >=2)
CNT_W, 16, width of burst length and sample counters

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE
abort  in  1  one-cycle pulse; ends any operation
burst_len  in  CNT_W  sample pairs per burst, sampled on accepted start; 0 = continuous
seed_in  in  192  seeds 1..6, seed1 at [31:0]; sampled on accepted start
seed_bus  out  192  latched seeds to generator urng_seed1..6
gen_rst  out  1  active-high reset to generator
awgn_in1  in  16  generator output 1, signed
awgn_in2  in  16  generator output 2, signed
m_valid  out  1  FIFO head valid
m_ready  in  1  consumer accepts head when m_valid & m_ready
m_data  out  32  {awgn_in2, awgn_in1} of FIFO head
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at burst completion
overflow_cnt  out  8  saturating count of dropped samples, cleared on accepted start

Behaviour:
- Reset values: state=IDLE, gen_rst=1, seed_bus=0, m_valid=0, m_data=0, busy=0, done=0, overflow_cnt=0, FIFO empty, counters 0.
- States:
  - IDLE: gen_rst=1. start -> SEED; latch seed_in and burst_len, clear overflow_cnt and FIFO.
  - SEED: gen_rst=1 for exactly SEED_CYCLES cycles -> WARMUP.
  - WARMUP: gen_rst=0; discard WARMUP_CYCLES samples -> RUN. If WARMUP_CYCLES=0, go straight to RUN.
  - RUN: gen_rst=0. Each cycle = one generated pair; increment gen_cnt. Push the pair if FIFO not full, else drop it and increment overflow_cnt (saturates at 255). Dropped pairs still count toward burst_len. When gen_cnt reaches burst_len (nonzero) -> DRAIN.
  - DRAIN: gen_rst=1, no pushes. When FIFO is empty: done=1 for one cycle -> IDLE.
- start outside IDLE is ignored.
- abort in any non-IDLE state -> IDLE next cycle: FIFO flushed, m_valid=0 next cycle, no done pulse, overflow_cnt retained.
- start and abort in the same IDLE cycle: abort wins, stay IDLE.
- FIFO:
  - First-word fall-through; m_data/m_valid registered from the head entry.
  - Push on cycle N is visible at m_valid on cycle N+1.
  - Push and pop in the same cycle when full: both occur, no drop (pop frees the slot).
  - Pop when empty: no-op.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter has log2(FIFO_DEPTH)+1 bits.
- m_data must stay stable while m_valid & !m_ready.
- burst_len=0: RUN continues until abort; done never pulses.
- Latency from accepted start to first m_valid: 1+SEED_CYCLES+WARMUP_CYCLES+1 cycles (defaults: 8).
- Reset asserted mid-operation: immediate return to reset values regardless of state.

Decomposition:
- Package awgn_pkg: state enumeration (IDLE, SEED, WARMUP, RUN, DRAIN), SEED_W=192, SAMPLE_W=16, overflow counter width 8.
- One sub-module: awgn_sample_fifo (parameterised depth/width, FWFT, push/pop/full/empty/flush).
- The FSM and counters stay in awgn_burst_ctrl.

Test Plan:
1. Reset low, then high; no start -> gen_rst=1, busy=0, m_valid=0, overflow_cnt=0 indefinitely.
2. start, burst_len=10, m_ready=1, defaults -> gen_rst high 2 cycles after start; first m_valid 8 cycles after start; exactly 10 pairs equal to model outputs; done pulses once; overflow_cnt=0.
3. burst_len=20, m_ready=0 throughout RUN, then 1 -> 4 pairs delivered (the first 4 generated), overflow_cnt=16, done after 4th pop.
4. Full FIFO with m_ready=1 continuously -> no drops; push and pop each cycle with m_data order preserved.
5. burst_len=0, abort after 50 RUN cycles -> IDLE next cycle, m_valid=0, no done; a following start with new seed_in shows new values on seed_bus.
6. Reset pulled low during RUN with 3 FIFO entries -> all outputs at reset values immediately; start while busy is ignored (burst_len unchanged).
